// File: rtl/emsg_expand_if.sv
// Handshake bundle for emsg_expand: compressed check message in, expanded edge beats out.
interface emsg_expand_if #(
  parameter int unsigned w    = 6,
  parameter int unsigned wabs = w - 1,
  parameter int unsigned wc   = 32,
  parameter int unsigned P    = 8
);
  localparam int unsigned ecw = 2 * wabs + 5 + wc;
  localparam int unsigned nb  = wc / P;
  localparam int unsigned iw  = (nb > 1) ? $clog2(nb) : 1;

  logic [ecw-1:0] ecomp;
  logic           in_valid;
  logic           in_ready;
  logic [w*P-1:0] out_msg;
  logic [iw-1:0]  out_idx;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output ecomp, in_valid, out_ready,
    input  in_ready, out_msg, out_idx, out_last, out_valid
  );

  modport slave (
    input  ecomp, in_valid, out_ready,
    output in_ready, out_msg, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/emsg_expand.sv
// Expands a min-sum compressed check message {min1, min2, pos, sign} into
// wc/P beats of P offset-corrected two's-complement edge messages.
module emsg_expand #(
  parameter int unsigned w    = 6,
  parameter int unsigned wabs = w - 1,
  parameter int unsigned wc   = 32,
  parameter int unsigned P    = 8,
  parameter int unsigned beta = 1
) (
  input  logic         clk,
  input  logic         rst,
  emsg_expand_if.slave bus
);

  localparam int unsigned nb = wc / P;
  localparam int unsigned iw = (nb > 1) ? $clog2(nb) : 1;
  localparam int unsigned ew = (wc > 1) ? $clog2(wc) : 1;
  localparam int unsigned ow = w * P;

  typedef struct packed {
    logic [wabs-1:0] min1;
    logic [wabs-1:0] min2;
    logic [4:0]      pos;
    logic [wc-1:0]   sign;
  } ecomp_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  ecomp_t          hold_q, hold_d;
  logic [iw-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [ow-1:0]   msg_q, msg_d;
  logic            ready_c;
  logic            in_hs;
  logic            out_hs;

  // One beat of edge messages; zero magnitude always encodes as +0.
  function automatic logic [ow-1:0] expand(input ecomp_t m, input logic [iw-1:0] idx);
    logic [ow-1:0]   res;
    logic [ew-1:0]   e;
    logic [wabs-1:0] mag;
    logic [wabs-1:0] omag;
    logic [w-1:0]    val;
    res = '0;
    for (int unsigned j = 0; j < P; j++) begin
      e    = ew'(32'(idx) * P + j);
      mag  = (32'(e) == 32'(m.pos)) ? m.min2 : m.min1;
      omag = (mag >= wabs'(beta)) ? (mag - wabs'(beta)) : '0;
      val  = w'(omag);
      res[w*j +: w] = m.sign[e] ? (w'(0) - val) : val;
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = EMIT;
      EMIT:    if (out_hs && last_q && !in_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshakes and next values of the registered outputs.
  always_comb begin
    ready_c = 1'b0;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (!rst) ready_c = (state_q == IDLE) || (last_q && bus.out_ready);
    in_hs  = bus.in_valid && ready_c;
    out_hs = valid_q && bus.out_ready;
    if (in_hs) begin
      hold_d  = ecomp_t'(bus.ecomp);
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (out_hs) begin
      if (last_q) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + iw'(1);
      end
    end
    last_d = valid_d && (cnt_d == iw'(nb - 1));
    msg_d  = expand(hold_d, cnt_d);
  end

  // Hold register, beat counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      msg_q   <= '0;
    end else begin
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      msg_q   <= msg_d;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_msg   = msg_q;
  assign bus.out_idx   = cnt_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_emsg_expand.sv
// Directed-vector bench for emsg_expand; a beta=1 and a beta=0 instance share one stimulus.
module tb_emsg_expand;

  logic        clk = 1'b0;
  logic        rst;
  logic [46:0] ecomp;
  logic        in_valid;
  logic        out_ready;
  logic        use_b0;

  always #5 clk = ~clk;

  emsg_expand_if #(.w(6), .wc(32), .P(8)) bus1 ();
  emsg_expand_if #(.w(6), .wc(32), .P(8)) bus0 ();

  assign bus1.ecomp     = ecomp;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;
  assign bus0.ecomp     = ecomp;
  assign bus0.in_valid  = in_valid;
  assign bus0.out_ready = out_ready;

  emsg_expand #(.w(6), .wc(32), .P(8), .beta(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  emsg_expand #(.w(6), .wc(32), .P(8), .beta(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic [47:0] o_msg;
  logic [1:0]  o_idx;
  logic        o_last, o_valid, o_iready;

  assign o_msg    = use_b0 ? bus0.out_msg   : bus1.out_msg;
  assign o_idx    = use_b0 ? bus0.out_idx   : bus1.out_idx;
  assign o_last   = use_b0 ? bus0.out_last  : bus1.out_last;
  assign o_valid  = use_b0 ? bus0.out_valid : bus1.out_valid;
  assign o_iready = use_b0 ? bus0.in_ready  : bus1.in_ready;

  // eo_*: edges other than pos, ep_*: edge pos; _p sign 0, _n sign 1 (hand-computed).
  typedef struct {
    logic [4:0]  min1;
    logic [4:0]  min2;
    logic [4:0]  pos;
    logic [31:0] sign;
    logic        b0;
    logic [5:0]  eo_p;
    logic [5:0]  eo_n;
    logic [5:0]  ep_p;
    logic [5:0]  ep_n;
  } vec_t;

  vec_t tbl [7];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [47:0] exp_beat(input vec_t v, input int k);
    logic [47:0] r;
    int          e;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      e = k * 8 + j;
      if (e == int'(v.pos)) r[6*j +: 6] = v.sign[5'(e)] ? v.ep_n : v.ep_p;
      else                  r[6*j +: 6] = v.sign[5'(e)] ? v.eo_n : v.eo_p;
    end
    return r;
  endfunction

  task automatic check_beat(input vec_t v, input int k, input string tag);
    logic [47:0] em;
    logic        el;
    em = exp_beat(v, k);
    el = (k == 3);
    n_vec++;
    if (o_valid !== 1'b1 || o_idx !== 2'(k) || o_last !== el || o_msg !== em) begin
      n_bad++;
      $display("FAIL %s beat %0d: got valid=%b idx=%0d last=%b msg=%h, want valid=1 idx=%0d last=%b msg=%h",
               tag, k, o_valid, o_idx, o_last, o_msg, k, el, em);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", tag, got, want);
    end
  endtask

  // Starts and ends just after a rising edge; returns right after the accepting edge.
  task automatic send(input vec_t v);
    bit done;
    done     = 1'b0;
    use_b0   = v.b0;
    ecomp    = {v.min1, v.min2, v.pos, v.sign};
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = (o_iready === 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL send: in_ready never seen within 20 cycles, want 1");
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    send(v);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_beat(v, k, $sformatf("vec%0d", id));
    end
    @(negedge clk);
    check_bit($sformatf("vec%0d out_valid after last", id), o_valid, 1'b0);
    check_bit($sformatf("vec%0d in_ready after last", id), o_iready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst       = 1'b1;
    ecomp     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    use_b0    = 1'b0;

    tbl[0] = '{5'd3,  5'd7,  5'd5,  32'h00000000, 1'b0, 6'h02, 6'h3E, 6'h06, 6'h3A};
    tbl[1] = '{5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00};
    tbl[2] = '{5'd31, 5'd31, 5'd31, 32'hAAAAAAAA, 1'b1, 6'h1F, 6'h21, 6'h1F, 6'h21};
    tbl[3] = '{5'd0,  5'd31, 5'd17, 32'h0F0F0F0F, 1'b0, 6'h00, 6'h00, 6'h1E, 6'h22};
    tbl[4] = '{5'd16, 5'd1,  5'd31, 32'h80000001, 1'b0, 6'h0F, 6'h31, 6'h00, 6'h00};
    tbl[5] = '{5'd0,  5'd5,  5'd2,  32'h12345678, 1'b1, 6'h00, 6'h00, 6'h05, 6'h3B};
    tbl[6] = '{5'd2,  5'd1,  5'd9,  32'hFFFF0000, 1'b0, 6'h01, 6'h3F, 6'h00, 6'h00};

    // Reset behaviour.
    @(negedge clk);
    check_bit("in_ready during reset", o_iready, 1'b0);
    check_bit("out_valid during reset", o_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("in_ready after reset", o_iready, 1'b1);
    check_bit("out_valid after reset", o_valid, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Backpressure: out_ready low for 3 cycles while beat 1 is presented.
    send(tbl[0]);
    @(negedge clk); check_beat(tbl[0], 0, "bp");
    @(negedge clk); check_beat(tbl[0], 1, "bp");
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_beat(tbl[0], 1, "bp hold");
      check_bit("bp in_ready while stalled", o_iready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk); check_beat(tbl[0], 2, "bp resume");
    @(negedge clk); check_beat(tbl[0], 3, "bp");
    @(negedge clk); check_bit("bp out_valid after last", o_valid, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back: next message offered during the last beat.
    send(tbl[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_beat(tbl[0], k, "b2b first");
    end
    ecomp    = {tbl[3].min1, tbl[3].min2, tbl[3].pos, tbl[3].sign};
    in_valid = 1'b1;
    @(negedge clk);
    check_beat(tbl[0], 3, "b2b first");
    check_bit("b2b in_ready on last beat", o_iready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_beat(tbl[3], k, "b2b second");
    end
    @(negedge clk); check_bit("b2b out_valid after last", o_valid, 1'b0);
    @(posedge clk);
    #1;

    // Reset pulse at beat 2 drops the rest of the message.
    send(tbl[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_beat(tbl[0], k, "rst mid");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("rst mid out_valid", o_valid, 1'b0);
    check_bit("rst mid in_ready", o_iready, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check_bit("rst mid stale beat seen", seen, 1'b0);

    // Fresh message after the mid-message reset.
    @(posedge clk);
    #1;
    run_vec(tbl[6], 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
